// File: rtl/loop_nest_pkg.sv
// Shared definitions for the loop nest engine: FSM state encoding and
// default parameter values used by the top level and its sub-module.
package loop_nest_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OUTER = 2'd1,
        ST_INNER = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_WIDTH   = 6;
    localparam int DEF_OUTER_N = 4;
    localparam int DEF_INNER_N = 4;
    localparam int DEF_Y_W     = 10;

endpackage

// File: rtl/loop_take_cond.sv
// Combinational inner-loop condition: parity of (outer index + operand)
// selects between "outer index is all ones" and "operand is non-zero".
module loop_take_cond
    import loop_nest_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IW    = 2
) (
    input  logic        [IW-1:0]    i_idx,
    input  logic signed [WIDTH-1:0] i_wire1,
    output logic                    o_take
);

    logic [WIDTH-1:0] w_sum;
    logic             w_parity;

    // XOR-reduce parity of a WIDTH-bit word
    function automatic logic parity_f(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

    // Index is zero-extended (or truncated) to WIDTH; sum wraps at WIDTH bits
    assign w_sum    = WIDTH'(i_idx) + i_wire1;
    assign w_parity = parity_f(w_sum);

    // Select the condition source according to the parity bit
    always_comb begin
        o_take = 1'b0;
        if (w_parity) begin
            o_take = &i_idx;
        end else begin
            o_take = (i_wire1 != {WIDTH{1'b0}});
        end
    end

endmodule

// File: rtl/loop_nest_engine.sv
// Two-level loop nest engine. A start request runs OUTER_N outer
// iterations; each outer iteration may run INNER_N inner iterations,
// counted in the saturating counter y. Optional feature macro:
// LOOP_ABORT_EN -- when defined, wire3 aborts a run from OUTER/INNER
// back to IDLE without a done pulse; otherwise wire3 is ignored.
module loop_nest_engine
    import loop_nest_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int OUTER_N = DEF_OUTER_N,
    parameter int INNER_N = DEF_INNER_N,
    parameter int Y_W     = DEF_Y_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wire0,
    input  logic signed [WIDTH-1:0] wire1,
    input  logic                    wire3,
    output logic [Y_W-1:0]          y,
    output logic                    busy,
    output logic                    done
);

    localparam int IW = $clog2(OUTER_N);
    localparam int JW = $clog2(INNER_N);

    localparam logic [IW-1:0]  I_LAST = IW'(OUTER_N - 1);
    localparam logic [JW-1:0]  J_LAST = JW'(INNER_N - 1);
    localparam logic [IW-1:0]  I_ONE  = IW'(1);
    localparam logic [JW-1:0]  J_ONE  = JW'(1);
    localparam logic [Y_W-1:0] Y_ONE  = Y_W'(1);
    localparam logic [Y_W-1:0] Y_MAX  = {Y_W{1'b1}};

    state_t          r_state;
    state_t          w_state_next;
    logic [IW-1:0]   r_i;
    logic [JW-1:0]   r_j;
    logic [Y_W-1:0]  r_y;
    logic            r_busy;
    logic            r_done;
    logic            w_busy_next;
    logic            w_done_next;
    logic            w_take;
    logic            w_abort;

`ifdef LOOP_ABORT_EN
    assign w_abort = wire3;
`else
    logic w_unused_abort;
    assign w_unused_abort = wire3;
    assign w_abort        = 1'b0;
`endif

    loop_take_cond #(
        .WIDTH (WIDTH),
        .IW    (IW)
    ) u_take_cond (
        .i_idx   (r_i),
        .i_wire1 (wire1),
        .o_take  (w_take)
    );

    // State register plus registered busy/done decoded from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
        end
    end

    // Next-state logic; a start is only honoured from IDLE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (wire0) begin
                    w_state_next = ST_OUTER;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_OUTER: begin
                if (w_abort) begin
                    w_state_next = ST_IDLE;
                end else if (w_take) begin
                    w_state_next = ST_INNER;
                end else if (r_i == I_LAST) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_OUTER;
                end
            end
            ST_INNER: begin
                if (w_abort) begin
                    w_state_next = ST_IDLE;
                end else if (r_j != J_LAST) begin
                    w_state_next = ST_INNER;
                end else if (r_i == I_LAST) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_OUTER;
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Output decode of the upcoming state so busy/done leave a flop
    always_comb begin
        w_busy_next = 1'b0;
        w_done_next = 1'b0;
        case (w_state_next)
            ST_OUTER: w_busy_next = 1'b1;
            ST_INNER: w_busy_next = 1'b1;
            ST_DONE:  w_done_next = 1'b1;
            default: begin
                w_busy_next = 1'b0;
                w_done_next = 1'b0;
            end
        endcase
    end

    // Loop indices and saturating inner-iteration counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_i <= {IW{1'b0}};
            r_j <= {JW{1'b0}};
            r_y <= {Y_W{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (wire0) begin
                        r_i <= {IW{1'b0}};
                        r_j <= {JW{1'b0}};
                        r_y <= {Y_W{1'b0}};
                    end
                end
                ST_OUTER: begin
                    if (!w_abort) begin
                        if (w_take) begin
                            r_j <= {JW{1'b0}};
                        end else if (r_i != I_LAST) begin
                            r_i <= r_i + I_ONE;
                        end
                    end
                end
                ST_INNER: begin
                    if (!w_abort) begin
                        if (r_y != Y_MAX) begin
                            r_y <= r_y + Y_ONE;
                        end
                        if (r_j != J_LAST) begin
                            r_j <= r_j + J_ONE;
                        end else if (r_i != I_LAST) begin
                            r_i <= r_i + I_ONE;
                        end
                    end
                end
                default: begin
                    r_i <= r_i;
                    r_j <= r_j;
                    r_y <= r_y;
                end
            endcase
        end
    end

    assign y    = r_y;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_loop_nest_engine.sv
// Self-checking bench for loop_nest_engine (WIDTH=6, OUTER_N=4, INNER_N=3)
// with a Y_W=10 instance and a Y_W=2 saturation instance on shared inputs.
// The reference model expands each accepted start into a schedule of
// cycle kinds and replays it; directed scenarios pin it with literals.
module tb_loop_nest_engine;

    localparam int WIDTH   = 6;
    localparam int OUTER_N = 4;
    localparam int INNER_N = 3;
    localparam int IW      = $clog2(OUTER_N);

`ifdef LOOP_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    wire0 = 1'b0;
    logic signed [WIDTH-1:0] wire1 = '0;
    logic                    wire3 = 1'b0;
    logic [9:0]              y_a;
    logic                    busy_a, done_a;
    logic [1:0]              y_b;
    logic                    busy_b, done_b;

    int n_checks = 0;
    int n_pass   = 0;

    // model: 0 idle, 1 outer, 2 inner, 3 done
    int m_kind = 0;
    int m_cnt  = 0;
    int m_q[$];

    loop_nest_engine #(.WIDTH(WIDTH), .OUTER_N(OUTER_N), .INNER_N(INNER_N), .Y_W(10)) dut (
        .clk(clk), .rst(rst), .wire0(wire0), .wire1(wire1), .wire3(wire3),
        .y(y_a), .busy(busy_a), .done(done_a));

    loop_nest_engine #(.WIDTH(WIDTH), .OUTER_N(OUTER_N), .INNER_N(INNER_N), .Y_W(2)) dut_sat (
        .clk(clk), .rst(rst), .wire0(wire0), .wire1(wire1), .wire3(wire3),
        .y(y_b), .busy(busy_b), .done(done_b));

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Expand one run into its sequence of cycle kinds for operand w1
    task automatic build(input int w1);
        int sum;
        bit take;
        for (int i = 0; i < OUTER_N; i++) begin
            m_q.push_back(1);
            sum  = (i + w1) % (1 << WIDTH);
            take = ($countones(sum) % 2 == 1) ? (i == (1 << IW) - 1) : (w1 != 0);
            if (take) for (int k = 0; k < INNER_N; k++) m_q.push_back(2);
        end
        m_q.push_back(3);
    endtask

    // Reference model, advanced on every clock edge or reset assertion
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_kind = 0; m_cnt = 0; m_q.delete();
        end else if (m_kind == 0) begin
            if (wire0) begin
                m_cnt = 0;
                m_q.delete();
                build(int'($unsigned(wire1)));
                m_kind = m_q.pop_front();
            end
        end else if (ABORT_EN && wire3 && (m_kind == 1 || m_kind == 2)) begin
            m_kind = 0; m_q.delete();
        end else begin
            if (m_kind == 2) m_cnt++;
            if (m_kind == 3 || m_q.size() == 0) m_kind = 0;
            else m_kind = m_q.pop_front();
        end
    end

    // Cycle-by-cycle comparison of both instances against the model
    always @(negedge clk) begin
        chk("busy_a", int'(busy_a), (m_kind == 1 || m_kind == 2) ? 1 : 0);
        chk("done_a", int'(done_a), (m_kind == 3) ? 1 : 0);
        chk("y_a",    int'(y_a),    (m_cnt > 1023) ? 1023 : m_cnt);
        chk("busy_b", int'(busy_b), (m_kind == 1 || m_kind == 2) ? 1 : 0);
        chk("done_b", int'(done_b), (m_kind == 3) ? 1 : 0);
        chk("y_b",    int'(y_b),    (m_cnt > 3) ? 3 : m_cnt);
    end

    // Start pulse in cycle 0; returns at the negedge of cycle 1
    task automatic start_run(input int w1);
        @(negedge clk);
        wire1 = WIDTH'(w1);
        wire0 = 1'b1;
        @(negedge clk);
        wire0 = 1'b0;
    endtask

    int dcnt;

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_done", int'(done_a), 0);
        chk("rst_y",    int'(y_a), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", int'(busy_a), 0);

        // wire1 = 0: four OUTER cycles, done at cycle 5, no inner work
        start_run(0);
        for (int k = 1; k <= 6; k++) begin
            chk("z_busy", int'(busy_a), (k <= 4) ? 1 : 0);
            chk("z_done", int'(done_a), (k == 5) ? 1 : 0);
            if (k == 6) chk("z_y", int'(y_a), 0);
            @(negedge clk);
        end

        // wire1 = 1: inner loop at i=2 and i=3; extra starts while busy/done ignored
        start_run(1);
        dcnt = 0;
        for (int k = 1; k <= 14; k++) begin
            dcnt += int'(done_a);
            wire0 = (k == 3 || k == 11) ? 1'b1 : 1'b0;
            if (k == 5)  chk("one_y_mid", int'(y_a), 1);
            if (k == 11) chk("one_done", int'(done_a), 1);
            if (k == 11) chk("one_y", int'(y_a), 6);
            if (k == 11) chk("one_ysat", int'(y_b), 3);
            if (k >= 12) chk("one_nostart", int'(busy_a), 0);
            @(negedge clk);
        end
        chk("one_done_cnt", dcnt, 1);

        // async reset in the middle of INNER, then a clean rerun
        start_run(1);
        repeat (4) @(negedge clk);
        chk("mr_y_before", int'(y_a), 1);
        #2 rst = 1'b1;
        #1;
        chk("mr_busy", int'(busy_a), 0);
        chk("mr_done", int'(done_a), 0);
        chk("mr_y",    int'(y_a), 0);
        chk("mr_ysat", int'(y_b), 0);
        @(negedge clk);
        rst = 1'b0;
        start_run(1);
        repeat (10) @(negedge clk);
        chk("mr_rerun_done", int'(done_a), 1);
        chk("mr_rerun_y", int'(y_a), 6);
        @(negedge clk);

        // abort request during INNER
        start_run(1);
        dcnt = 0;
        for (int k = 1; k <= 13; k++) begin
            dcnt += int'(done_a);
            wire3 = (k == 5) ? 1'b1 : 1'b0;
`ifdef LOOP_ABORT_EN
            if (k == 6)  chk("ab_busy", int'(busy_a), 0);
            if (k == 12) chk("ab_y", int'(y_a), 1);
`else
            if (k == 12) chk("ab_y", int'(y_a), 6);
`endif
            @(negedge clk);
        end
        chk("ab_done_cnt", dcnt, ABORT_EN ? 0 : 1);

        // randomized traffic; operand only changes while the model is idle
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (m_kind == 0) begin
                case ($urandom_range(0, 3))
                    0:       wire1 = '0;
                    1:       wire1 = 6'sd1;
                    default: wire1 = WIDTH'($urandom_range(0, 63));
                endcase
            end
            wire0 = ($urandom_range(0, 3) == 0);
            wire3 = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 199) == 0) begin
                #2 rst = 1'b1;
                #1 rst = 1'b0;
            end
        end
        @(negedge clk);
        wire0 = 1'b0;
        wire3 = 1'b0;
        repeat (20) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
